// File: rtl/alt_pcie_ast64_tlp_enc.sv
// alt_pcie_ast64_tlp_enc: serialises one MRd/MWr/Cpl/CplD TLP onto the 64-bit Avalon-ST PCIe TX port.
// Define ALT_PCIE_TLP_ENC_ADDR64_AUTO_EN to send 4DW memory requests below 4 GB as 3DW.
module alt_pcie_ast64_tlp_enc #(
  parameter int P_MAX_PAYLOAD_DW = 256
) (
  input  logic        i_Clk,
  input  logic        i_ARst,
  input  logic        i_ReqValid,
  output logic        o_ReqReady,
  output logic        o_ReqErr,
  input  logic [1:0]  i2_Fmt,
  input  logic [4:0]  i5_Type,
  input  logic [2:0]  i3_TrfcCls,
  input  logic [1:0]  i2_Attr,
  input  logic        i_EP,
  input  logic [9:0]  i10_Length,
  input  logic [63:0] i64_Addr,
  input  logic [15:0] i16_ReqID,
  input  logic [7:0]  i8_Tag,
  input  logic [3:0]  i4_LastDWBE,
  input  logic [3:0]  i4_FrstDWBE,
  input  logic [15:0] i16_CplID,
  input  logic [2:0]  i3_CplStatus,
  input  logic [11:0] i12_CmplByteCnt,
  input  logic [6:0]  i7_LowerAddr,
  input  logic [63:0] iv64_Data,
  output logic        o_DataRd,
  output logic        o_AstTxSop,
  output logic        o_AstTxEop,
  output logic        o_AstTxEmpty,
  output logic        o_AstTxDv,
  output logic [63:0] ov64_AstTxData,
  input  logic        i_AstTxReady
);
  typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} state_t;
  state_t state_q, hdr1_d;
  logic rdy_q, err_q, four_q, data_q, cpl_q, ep_q;
  logic [1:0] fmt_q, attr_q;
  logic [4:0] type_q;
  logic [2:0] tc_q, sts_q;
  logic [9:0] len_q;
  logic [63:2] addr_q;
  logic [15:0] reqid_q, cplid_q;
  logic [7:0] tag_q, be_q;
  logic [11:0] bcnt_q;
  logic [6:0] laddr_q;
  logic [10:0] rem_q, len_d;
  logic [31:0] hold_q, dw0, dw1, dw2;
  logic [1:0] fmt_d;
  logic is_cpl, shrink, four_d, big, accept, xfer, one, last, s_h0, s_h1, s_dt, unused_addr;
  assign is_cpl = i5_Type == 5'b01010;
`ifdef ALT_PCIE_TLP_ENC_ADDR64_AUTO_EN
  assign shrink = (i5_Type[4:1] == 4'b0) & i2_Fmt[0] & (i64_Addr[63:32] == 32'h0);
`else
  assign shrink = 1'b0;
`endif
  assign unused_addr = &{1'b0, i64_Addr[1:0]};
  assign fmt_d = {i2_Fmt[1], i2_Fmt[0] & ~shrink};
  assign four_d = fmt_d[0] & ~is_cpl;
  assign len_d = {i10_Length == 10'd0, i10_Length};
  assign big = i2_Fmt[1] & (len_d > 11'(P_MAX_PAYLOAD_DW));
  assign accept = i_ReqValid & rdy_q;
  assign xfer = o_AstTxDv & i_AstTxReady;
  assign one = rem_q == 11'd1;
  assign last = rem_q <= 11'd2;
  assign s_h0 = state_q == HDR0;
  assign s_h1 = state_q == HDR1;
  assign s_dt = state_q == DATA;
  // 3DW layouts carry one payload DW in the second header beat, so they leave HDR1 one DW ahead
  assign hdr1_d = data_q & (four_q | ~one) ? DATA : IDLE;
  assign dw0 = {1'b0, fmt_q, type_q, 1'b0, tc_q, 4'b0, 1'b0, ep_q, attr_q, 2'b0, len_q};
  assign dw1 = cpl_q ? {cplid_q, sts_q, 1'b0, bcnt_q} : {reqid_q, tag_q, be_q};
  assign dw2 = cpl_q ? {reqid_q, tag_q, 1'b0, laddr_q} : {addr_q[31:2], 2'b0};
  assign o_ReqReady = rdy_q;
  assign o_ReqErr = err_q;
  assign o_AstTxDv = state_q != IDLE;
  assign o_AstTxSop = s_h0;
  assign o_AstTxEop = (s_h1 & (~data_q | (~four_q & one))) | (s_dt & last);
  assign o_AstTxEmpty = (s_h1 & ~data_q & ~four_q) | (s_dt & one);
  assign o_DataRd = i_AstTxReady & ((s_h1 & data_q & ~four_q) | (s_dt & (four_q | ~one)));
  assign ov64_AstTxData = s_h0 ? {dw1, dw0} :
                          s_h1 ? (four_q ? {addr_q[31:2], 2'b0, addr_q[63:32]} : {data_q ? iv64_Data[31:0] : 32'h0, dw2}) :
                          s_dt ? (four_q ? iv64_Data : {one ? 32'h0 : iv64_Data[31:0], hold_q}) : 64'h0;
  always_ff @(posedge i_Clk or posedge i_ARst)
    if (i_ARst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      four_q  <= 1'b0;
      data_q  <= 1'b0;
      cpl_q   <= 1'b0;
      ep_q    <= 1'b0;
      fmt_q   <= '0;
      attr_q  <= '0;
      type_q  <= '0;
      tc_q    <= '0;
      sts_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      reqid_q <= '0;
      cplid_q <= '0;
      tag_q   <= '0;
      be_q    <= '0;
      bcnt_q  <= '0;
      laddr_q <= '0;
      rem_q   <= '0;
      hold_q  <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rdy_q <= ~(accept & ~big);
          if (accept) begin
            four_q  <= four_d;
            data_q  <= i2_Fmt[1];
            cpl_q   <= is_cpl;
            ep_q    <= i_EP;
            fmt_q   <= fmt_d;
            attr_q  <= i2_Attr;
            type_q  <= i5_Type;
            tc_q    <= i3_TrfcCls;
            sts_q   <= i3_CplStatus;
            len_q   <= i10_Length;
            addr_q  <= i64_Addr[63:2];
            reqid_q <= i16_ReqID;
            cplid_q <= i16_CplID;
            tag_q   <= i8_Tag;
            be_q    <= {i4_LastDWBE, i4_FrstDWBE};
            bcnt_q  <= i12_CmplByteCnt;
            laddr_q <= i7_LowerAddr;
            rem_q   <= i2_Fmt[1] ? len_d : 11'd0;
            err_q   <= big;
            state_q <= big ? IDLE : HDR0;
          end
        end
        HDR0: state_q <= xfer ? HDR1 : HDR0;
        HDR1: if (xfer) begin
          hold_q  <= iv64_Data[63:32];
          rem_q   <= four_q ? rem_q : rem_q - 11'd1;
          state_q <= hdr1_d;
          rdy_q   <= hdr1_d == IDLE;
        end
        default: if (xfer) begin
          hold_q  <= iv64_Data[63:32];
          rem_q   <= rem_q - 11'd2;
          state_q <= last ? IDLE : DATA;
          rdy_q   <= last;
        end
      endcase
    end
endmodule
